// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Stores only know B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= F3_W);
    return (f3 != 3'd3) && (f3 < 3'd6);
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store byte-enables and replicated write data, load lane extraction and extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata;
    rdata_c = '0;
    byte_v  = 8'(rword >> {lane, 3'b000});
    half_v  = lane[1] ? rword[31:16] : rword[15:0];

    // Replicating the low bytes across the word lets the byte-enables pick the lane.
    case (funct3[1:0])
      2'd0: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      2'd2:    be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase

    case (funct3)
      F3_B:    rdata_c = {{24{byte_v[7]}}, byte_v};
      F3_H:    rdata_c = {{16{half_v[15]}}, half_v};
      F3_W:    rdata_c = rword;
      F3_BU:   rdata_c = {24'd0, byte_v};
      F3_HU:   rdata_c = {16'd0, half_v};
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding RV32I data-memory responder with valid/ready request and response channels.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states between acceptance and response.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_resp: WAIT_CYCLES must be within 1..15");
  end

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;

`ifdef DMEM_WAIT_EN
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;

  assign cur_we    = we_q;
  assign cur_addr  = addr_q;
  assign cur_wdata = wdata_q;
  assign cur_f3    = f3_q;
`else
  // Without wait states the array is accessed on the acceptance edge itself.
  assign cur_we    = req_we;
  assign cur_addr  = req_addr;
  assign cur_wdata = req_wdata;
  assign cur_f3    = req_funct3;
`endif

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx_c;
  logic [31:0] rword_c, wr_c, ld_c;
  logic [3:0]  be_c;
  logic        err_c, misalign_c, range_c, enter_resp_c, mem_we_c;

  assign idx_c   = cur_addr[AW+1:2];
  assign rword_c = mem_q[idx_c];

  dmem_align u_align (
    .funct3  (cur_f3),
    .lane    (cur_addr[1:0]),
    .wdata   (cur_wdata),
    .rword   (rword_c),
    .be_c    (be_c),
    .wdata_c (wr_c),
    .rdata_c (ld_c)
  );

  always_comb begin
    misalign_c = ((cur_f3[1:0] == 2'd1) && cur_addr[0]) ||
                 ((cur_f3[1:0] == 2'd2) && (cur_addr[1:0] != 2'b00));
    range_c    = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
    err_c      = !f3_legal(cur_we, cur_f3) || misalign_c || range_c;
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    valid_d      = valid_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    enter_resp_c = 1'b0;
`ifdef DMEM_WAIT_EN
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ready_d = 1'b0;
`ifdef DMEM_WAIT_EN
          state_d = WAIT;
          cnt_d   = WCNT_W'(WAIT_CYCLES);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
`else
          state_d      = RESP;
          enter_resp_c = 1'b1;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        if (cnt_q == WCNT_W'(1)) begin
          state_d      = RESP;
          cnt_d        = '0;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - WCNT_W'(1);
        end
      end
`endif
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          ready_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sample and store commit share the edge that enters RESP.
    if (enter_resp_c) begin
      valid_d = 1'b1;
      err_d   = err_c;
      rdata_d = (err_c || cur_we) ? '0 : ld_c;
    end
    mem_we_c = enter_resp_c && cur_we && !err_c && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_WAIT_EN
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef DMEM_WAIT_EN
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
`endif
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wr_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: byte-array reference model plus directed literal checks.
// Builds with or without DMEM_WAIT_EN; expected latency follows the macro.
module tb_dmem_resp;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WAITC + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and one transaction in flight.
  logic [7:0]  mem_b [4*DEPTH];
  logic        busy = 1'b0, committed = 1'b0;
  int          edges = 0, acc_edge = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_f3;
  logic [31:0] exp_rdata;
  logic        exp_err;

  task automatic model_exec(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int unsigned size;
    logic [31:0] v;
    rd = '0;
    e  = 1'b0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (we && f3 > 3'd2) size = 0;
    if (size == 0 || (addr / 4) >= DEPTH || (addr % size) != 0) begin
      e = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < int'(size); i++) mem_b[addr + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mem_b[addr + i];
      if (f3 < 3'd4 && size < 4 && v[8*size-1])
        for (int b = 8 * int'(size); b < 32; b++) v[b] = 1'b1;
      rd = v;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      = 1'b0;
      committed = 1'b0;
    end else begin
      edges++;
      if (busy && committed && resp_ready) begin
        busy      = 1'b0;
        committed = 1'b0;
      end else if (!busy && req_valid) begin
        busy     = 1'b1;
        acc_edge = edges;
        p_we     = req_we;
        p_addr   = req_addr;
        p_wdata  = req_wdata;
        p_f3     = req_funct3;
      end
      if (busy && !committed && edges == acc_edge + LAT - 1) begin
        model_exec(p_we, p_addr, p_f3, p_wdata, exp_rdata, exp_err);
        if (p_we) exp_rdata = '0;
        committed = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(busy && committed));
      if (busy && committed) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    wait_idle();
    if (!req_ready) return;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    req_we     = ~we;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", 32'(resp_valid), 32'd1);
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4 * int'(DEPTH); i++) mem_b[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    txn(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw10_err", 32'(er), 32'd0);
    chk("sw10_lat", 32'(lat), 32'(LAT));
    txn(1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw10_rdata", rd, 32'hDEADBEEF);
    chk("lw10_err", 32'(er), 32'd0);
    chk("lw10_lat", 32'(lat), 32'(LAT));

    txn(1'b1, 32'h11, 3'd0, 32'h12345680, 0, rd, er, lat);
    txn(1'b0, 32'h11, 3'd0, 32'h0, 0, rd, er, lat);
    chk("lb11", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h11, 3'd4, 32'h0, 0, rd, er, lat);
    chk("lbu11", rd, 32'h00000080);
    txn(1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw10_after_sb", rd, 32'hDEAD80EF);

    txn(1'b0, 32'h12, 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw12_err", 32'(er), 32'd1);
    chk("lw12_rdata", rd, 32'd0);
    txn(1'b1, 32'h13, 3'd1, 32'h0000AAAA, 0, rd, er, lat);
    chk("sh13_err", 32'(er), 32'd1);
    txn(1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw10_after_sh13", rd, 32'hDEAD80EF);
    txn(1'b0, 32'(4 * DEPTH), 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw_oor_err", 32'(er), 32'd1);

    txn(1'b1, 32'(4 * DEPTH - 4), 3'd2, 32'h0BADF00D, 0, rd, er, lat);
    chk("sw_last_err", 32'(er), 32'd0);
    txn(1'b0, 32'(4 * DEPTH - 4), 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw_last", rd, 32'h0BADF00D);

    txn(1'b1, 32'h14, 3'd2, 32'hCAFEF00D, 0, rd, er, lat);
    txn(1'b0, 32'h16, 3'd1, 32'h0, 5, rd, er, lat);
    chk("lh16_hold", rd, 32'hFFFFCAFE);
    txn(1'b0, 32'h16, 3'd5, 32'h0, 0, rd, er, lat);
    chk("lhu16", rd, 32'h0000CAFE);

    // Reset one cycle after accepting a store to 0x20.
    txn(1'b1, 32'h20, 3'd2, 32'h11223344, 0, rd, er, lat);
    wait_idle();
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = 3'd2;
    req_wdata  = 32'h12345678;
    req_valid  = 1'b1;
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    txn(1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er, lat);
`ifdef DMEM_WAIT_EN
    chk("lw20_after_rst", rd, 32'h11223344);
`else
    chk("lw20_after_rst", rd, 32'h12345678);
`endif

    txn(1'b0, 32'h0, 3'd3, 32'h0, 0, rd, er, lat);
    chk("ld_f3_3_err", 32'(er), 32'd1);
    chk("ld_f3_3_rdata", rd, 32'd0);
    txn(1'b1, 32'h10, 3'd4, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("st_f3_4_err", 32'(er), 32'd1);
    txn(1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er, lat);
    chk("lw10_after_st_f3_4", rd, 32'hDEAD80EF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted per transaction when DMEM_WAIT_EN is defined; legal range 1..15.
REQ-003 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Ports req_valid in 1 (request present) and req_ready out 1 (responder can accept).
REQ-006 Port req_we  in  1  request type: 1 = store, 0 = load.
REQ-007 Port req_addr  in  32  byte address.
REQ-008 Port req_funct3  in  3  RV32I load/store width code: LB/LH/LW/LBU/LHU, SB/SH/SW.
REQ-009 Port req_wdata  in  32  store data, taken from the low bytes.
REQ-010 Ports resp_valid out 1 (response present) and resp_ready in 1 (requester can take the response).
REQ-011 Port resp_rdata  out  32  load result; 0 for stores and for errors.
REQ-012 Port resp_err  out  1  1 = request was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE.
REQ-015 A request is accepted on a cycle with req_valid=1 and req_ready=1; all req_* inputs are captured on that edge.
REQ-016 Without DMEM_WAIT_EN: IDLE goes directly to RESP on acceptance, so resp_valid is 1 in the cycle after acceptance.
REQ-017 With DMEM_WAIT_EN: IDLE goes to WAIT on acceptance; WAIT holds for WAIT_CYCLES cycles (down-counter), then goes to RESP, so resp_valid rises WAIT_CYCLES+1 cycles after acceptance.
REQ-018 In RESP, resp_valid=1 and resp_rdata/resp_err are stable until resp_ready=1; on that handshake the FSM returns to IDLE.
REQ-019 Minimum spacing between acceptances is 2 cycles; requests are never pipelined or queued.
REQ-020 Error conditions:
  - LH/LHU/SH with addr[0]!=0;
  - LW/SW with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS;
  - load funct3 of 3, 6 or 7;
  - store funct3 greater than 2.
REQ-021 An erroring request still produces a response, with resp_err=1, resp_rdata=0 and no memory write.
REQ-022 A store commits on the edge that enters RESP:
  - SB writes byte lane addr[1:0];
  - SH writes halfword lane addr[1];
  - SW writes the full word;
  - all other bytes are unchanged.
REQ-023 A load samples the array on the edge that enters RESP.
  - Byte/halfword results are taken from the addressed lane.
  - LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 A load issued after a store to the same address returns the stored data (the store has already committed).
REQ-025 req_valid while not in IDLE is ignored; the requester must hold it.

Reset
REQ-026 While rst=1: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
REQ-027 Reset asserted during WAIT or RESP drops the transaction in progress; a store that has not yet committed SHALL NOT write.
REQ-028 Data array contents are not cleared by reset.

Configuration
REQ-029 Macro DMEM_WAIT_EN:
  - Defined: WAIT state and a 4-bit wait counter are built; latency follows REQ-017.
  - Undefined: WAIT state and counter are absent; latency follows REQ-016 and WAIT_CYCLES is ignored.

Structure
REQ-030 Shared package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state encoding (IDLE/WAIT/RESP);
  - the wait-counter width constant.
REQ-031 One combinational sub-module, dmem_align, is built: it generates byte-enables and shifted write data, and performs load lane extraction and sign/zero extension.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; latency 1 cycle (no macro) or 3 cycles (macro, WAIT_CYCLES=2).
REQ-033 SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-034 Misalignment and range errors:
  - LW addr 0x12 -> resp_err=1, resp_rdata=0;
  - SH addr 0x13 -> resp_err=1 and word 0x10 unchanged;
  - LW addr 4*DEPTH_WORDS -> resp_err=1.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1 with stable data and req_ready stays 0; handshake -> IDLE next cycle.
REQ-036 Assert rst during WAIT of SW addr 0x20 data 0x12345678 -> outputs return to reset values; a later LW 0x20 returns the previous contents.
REQ-037 Load funct3=3 at addr 0x0 -> resp_err=1; store funct3=4 -> resp_err=1 and memory unchanged.
